// File: rtl/fetch_pkg.sv
// Shared fetch definitions: sequencer state encoding, reset PC and the
// branch-class opcode encodings also used by the branch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [18:0] RESET_PC_DEFAULT = 19'd0;

  localparam logic [4:0] OP_BR_EQ  = 5'b01010;
  localparam logic [4:0] OP_BR_NE  = 5'b01011;
  localparam logic [4:0] OP_BR_JMP = 5'b01100;

  function automatic logic is_branch_op(input logic [4:0] op);
    return (op == OP_BR_EQ) || (op == OP_BR_NE) || (op == OP_BR_JMP);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for the
// debug-visible branch statistics.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_fetch_sequencer.sv
// Fetch PC owner: sequential predict-not-taken fetch over a req/ack
// instruction memory, taken-branch redirect with a timed flush pulse.
module branch_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              PC_W         = 19,
  parameter int              INSTR_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC     = PC_W'(RESET_PC_DEFAULT),
  parameter int              FLUSH_CYCLES = 2,
  parameter int              STAT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               br_valid,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    target_address,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               flush,
  output logic [STAT_W-1:0]  stat_branches,
  output logic [STAT_W-1:0]  stat_taken
);

  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  fetch_state_t    state;
  logic [1:0]      flush_cnt;
  logic [1:0]      flush_cnt_n;
  logic            flush_n;
  logic [PC_W-1:0] drain_target;
  logic            redirect;
  logic            issue;

  assign redirect = br_valid & branch_taken;

  always_comb begin
    flush_n     = flush;
    flush_cnt_n = flush_cnt;
    if (redirect) begin
      flush_n     = 1'b1;
      flush_cnt_n = FLUSH_LAST;
    end else if (flush_cnt != 2'd0) begin
      flush_cnt_n = flush_cnt - 2'd1;
    end else begin
      flush_n = 1'b0;
    end
  end

  // A new request may start only once the next cycle is the last flush
  // cycle, so its data lands after flush drops and if_valid never overlaps it.
  assign issue = (flush_cnt_n == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= '0;
      flush        <= 1'b0;
      flush_cnt    <= 2'd0;
      drain_target <= RESET_PC;
    end else begin
      flush     <= flush_n;
      flush_cnt <= flush_cnt_n;
      case (state)
        BOOT: begin
          state     <= REQ;
          imem_req  <= issue;
          imem_addr <= redirect ? target_address : RESET_PC;
        end
        REQ: begin
          if (redirect) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            if (imem_req && !imem_ack) begin
              drain_target <= target_address;
              state        <= DRAIN;
            end else begin
              imem_addr <= target_address;
              imem_req  <= issue;
            end
          end else if (!imem_req) begin
            imem_req <= issue;
          end else if (imem_ack) begin
            if_valid  <= 1'b1;
            if_instr  <= imem_rdata;
            if_pc     <= imem_addr;
            imem_addr <= imem_addr + PC_W'(1);
            if (stall) begin
              imem_req <= 1'b0;
              state    <= HOLD;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            if_valid  <= 1'b0;
            if_instr  <= '0;
            if_pc     <= '0;
            imem_addr <= target_address;
            imem_req  <= issue;
            state     <= REQ;
          end else if (!stall) begin
            if_valid <= 1'b0;
            imem_req <= issue;
            state    <= REQ;
          end
        end
        DRAIN: begin
          // Address and req stay frozen until the abandoned fetch completes.
          if (redirect) drain_target <= target_address;
          if (imem_ack) begin
            imem_addr <= redirect ? target_address : drain_target;
            imem_req  <= issue;
            state     <= REQ;
          end
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(STAT_W)) u_stat_branches (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_valid),
    .clear (1'b0),
    .count (stat_branches)
  );

  sat_counter #(.WIDTH(STAT_W)) u_stat_taken (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect),
    .clear (1'b0),
    .count (stat_taken)
  );

endmodule

// File: tb/tb_branch_fetch_sequencer.sv
// Scoreboard bench: expected handshake addresses and delivered instructions
// are queued up front; negedge monitors pop and compare as the DUT emits them.
module tb_branch_fetch_sequencer;

  localparam int PC_W    = 19;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               stall = 1'b0;
  logic               br_valid = 1'b0;
  logic               branch_taken = 1'b0;
  logic [PC_W-1:0]    target_address = '0;
  logic               imem_ack = 1'b0;
  logic [INSTR_W-1:0] imem_rdata;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               flush;
  logic [15:0]        stat_branches;
  logic [15:0]        stat_taken;

  logic               sat_imem_req;
  logic [PC_W-1:0]    sat_imem_addr;
  logic               sat_if_valid;
  logic [INSTR_W-1:0] sat_if_instr;
  logic [PC_W-1:0]    sat_if_pc;
  logic               sat_flush;
  logic [3:0]         sat_stat_branches;
  logic [3:0]         sat_stat_taken;

  int vectors = 0;
  int miscompares = 0;

  logic [PC_W-1:0] req_q[$];
  logic [PC_W-1:0] fetch_q[$];
  logic            prev_valid = 1'b0;
  logic [PC_W-1:0] prev_pc = '0;

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] a);
    return {13'h1A5, a};
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  branch_fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .br_valid       (br_valid),
    .branch_taken   (branch_taken),
    .target_address (target_address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .flush          (flush),
    .stat_branches  (stat_branches),
    .stat_taken     (stat_taken)
  );

  branch_fetch_sequencer #(.STAT_W(4)) dut_sat (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .br_valid       (br_valid),
    .branch_taken   (branch_taken),
    .target_address (target_address),
    .imem_req       (sat_imem_req),
    .imem_addr      (sat_imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (sat_if_valid),
    .if_instr       (sat_if_instr),
    .if_pc          (sat_if_pc),
    .flush          (sat_flush),
    .stat_branches  (sat_stat_branches),
    .stat_taken     (sat_stat_taken)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_addr(input logic [PC_W-1:0] a);
    int n = 0;
    while (!(imem_req && imem_addr == a) && n < 200) begin
      step();
      n++;
    end
    check("wait_addr_reached", {13'd0, imem_addr}, {13'd0, a});
  endtask

  task automatic branch(input logic taken, input logic [PC_W-1:0] tgt);
    br_valid       = 1'b1;
    branch_taken   = taken;
    target_address = tgt;
    step();
    br_valid     = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic push_req(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) req_q.push_back(PC_W'(i));
  endtask

  task automatic push_fetch(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) fetch_q.push_back(PC_W'(i));
  endtask

  // Handshake monitor: every req&ack must carry the next expected address.
  always @(negedge clk) begin
    if (!rst && imem_req && imem_ack) begin
      if (req_q.size() == 0) begin
        check("unexpected_handshake", {13'd0, imem_addr}, 32'hFFFF_FFFF);
      end else begin
        check("handshake_addr", {13'd0, imem_addr}, {13'd0, req_q.pop_front()});
      end
    end
  end

  // Delivery monitor: a new instruction is one whose pc differs from the
  // one already on the IF/ID port (a held item is not re-counted).
  always @(negedge clk) begin
    logic [PC_W-1:0] e;
    if (!rst) begin
      if (flush) check("no_valid_during_flush", {31'd0, if_valid}, 32'd0);
      if (if_valid && !(prev_valid && if_pc == prev_pc)) begin
        if (fetch_q.size() == 0) begin
          check("unexpected_delivery", {13'd0, if_pc}, 32'hFFFF_FFFF);
        end else begin
          e = fetch_q.pop_front();
          check("if_pc", {13'd0, if_pc}, {13'd0, e});
          check("if_instr", if_instr, instr_of(e));
        end
      end
      prev_valid = if_valid;
      prev_pc    = if_pc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    push_req(0, 10);   push_req(143, 148); push_req(20, 20); push_req(143, 145);
    push_req(3, 8);    push_req(19'h7FFFF, 19'h7FFFF);      push_req(0, 1);
    push_fetch(0, 9);  push_fetch(143, 147); push_fetch(143, 144);
    push_fetch(3, 7);  push_fetch(19'h7FFFF, 19'h7FFFF);    push_fetch(0, 1);

    step();
    step();
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_imem_addr", {13'd0, imem_addr}, 32'd0);
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_pc", {13'd0, if_pc}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_stat_branches", {16'd0, stat_branches}, 32'd0);
    check("rst_stat_taken", {16'd0, stat_taken}, 32'd0);

    rst      = 1'b0;
    imem_ack = 1'b1;
    check("boot_no_req", {31'd0, imem_req}, 32'd0);
    step();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", {13'd0, imem_addr}, 32'd0);
    step();
    check("seq_addr1", {13'd0, imem_addr}, 32'd1);
    check("seq_valid_pc0", {31'd0, if_valid}, 32'd1);

    // taken branch at fetch of 10 -> 143
    wait_addr(19'd10);
    branch(1'b1, 19'd143);
    check("redir_flush1", {31'd0, flush}, 32'd1);
    check("redir_addr", {13'd0, imem_addr}, 32'd143);
    check("redir_if_valid", {31'd0, if_valid}, 32'd0);
    check("redir_stat_br", {16'd0, stat_branches}, 32'd1);
    check("redir_stat_tk", {16'd0, stat_taken}, 32'd1);
    step();
    check("redir_flush2", {31'd0, flush}, 32'd1);
    check("redir_req", {31'd0, imem_req}, 32'd1);
    step();
    check("redir_flush_end", {31'd0, flush}, 32'd0);
    check("redir_first_pc", {13'd0, if_pc}, 32'd143);

    // not-taken branch: only stat_branches moves
    wait_addr(19'd146);
    branch(1'b0, 19'd50);
    check("nt_flush", {31'd0, flush}, 32'd0);
    check("nt_addr", {13'd0, imem_addr}, 32'd147);
    check("nt_stat_br", {16'd0, stat_branches}, 32'd2);
    check("nt_stat_tk", {16'd0, stat_taken}, 32'd1);

    // redirect while a request is outstanding without ack
    wait_addr(19'd148);
    branch(1'b1, 19'd20);
    imem_ack = 1'b0;
    step();
    check("pre_drain_addr", {13'd0, imem_addr}, 32'd20);
    branch(1'b1, 19'd143);
    check("drain_req", {31'd0, imem_req}, 32'd1);
    check("drain_addr0", {13'd0, imem_addr}, 32'd20);
    check("drain_flush", {31'd0, flush}, 32'd1);
    step();
    check("drain_addr1", {13'd0, imem_addr}, 32'd20);
    step();
    check("drain_addr2", {13'd0, imem_addr}, 32'd20);
    check("drain_flush_end", {31'd0, flush}, 32'd0);
    imem_ack = 1'b1;
    step();
    check("drain_discard", {31'd0, if_valid}, 32'd0);
    check("drain_new_addr", {13'd0, imem_addr}, 32'd143);
    check("drain_new_req", {31'd0, imem_req}, 32'd1);
    check("drain_stat_br", {16'd0, stat_branches}, 32'd4);
    check("drain_stat_tk", {16'd0, stat_taken}, 32'd3);

    // stall raised with the ack of 5
    wait_addr(19'd145);
    branch(1'b1, 19'd3);
    wait_addr(19'd5);
    stall = 1'b1;
    step();
    check("hold_req", {31'd0, imem_req}, 32'd0);
    check("hold_valid", {31'd0, if_valid}, 32'd1);
    check("hold_pc", {13'd0, if_pc}, 32'd5);
    step();
    check("hold_req2", {31'd0, imem_req}, 32'd0);
    check("hold_instr2", if_instr, instr_of(19'd5));
    stall = 1'b0;
    step();
    check("unhold_valid", {31'd0, if_valid}, 32'd0);
    check("unhold_addr", {13'd0, imem_addr}, 32'd6);
    check("unhold_req", {31'd0, imem_req}, 32'd1);

    // PC wrap at the top of the address space
    wait_addr(19'd8);
    branch(1'b1, 19'h7FFFF);
    wait_addr(19'h7FFFF);
    step();
    check("wrap_addr", {13'd0, imem_addr}, 32'd0);
    wait_addr(19'd2);
    imem_ack = 1'b0;
    repeat (3) step();
    check("req_q_drained", req_q.size(), 32'd0);
    check("fetch_q_drained", fetch_q.size(), 32'd0);
    check("mid_stat_br", {16'd0, stat_branches}, 32'd6);
    check("mid_stat_tk", {16'd0, stat_taken}, 32'd5);

    // saturation: 12 more taken branches, 4-bit instance pegs at 4'hF
    br_valid       = 1'b1;
    branch_taken   = 1'b1;
    target_address = 19'd100;
    repeat (12) step();
    br_valid     = 1'b0;
    branch_taken = 1'b0;
    step();
    check("end_stat_br", {16'd0, stat_branches}, 32'd18);
    check("end_stat_tk", {16'd0, stat_taken}, 32'd17);
    check("sat_stat_br", {28'd0, sat_stat_branches}, 32'hF);
    check("sat_stat_tk", {28'd0, sat_stat_taken}, 32'hF);
    check("sat_req", {31'd0, sat_imem_req}, 32'd1);
    check("sat_addr", {13'd0, sat_imem_addr}, 32'd2);
    check("sat_valid", {31'd0, sat_if_valid}, 32'd0);
    check("sat_instr", sat_if_instr, 32'd0);
    check("sat_pc", {13'd0, sat_if_pc}, 32'd0);
    check("sat_flush", {31'd0, sat_flush}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
